// File: rtl/kisc_bus_pkg.sv
// Shared types for the APB bus arbiter: FSM states, access size codes,
// and requester (owner) identifiers.
package kisc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    ERR_RSP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-strobe and alignment decode for a load/store request.
// Ports: size    - access size code (byte/half/word/reserved)
//        addr_lo - low two address bits
//        strb    - byte lanes touched by the access
//        misalign- request cannot be issued on APB
module apb_strb_gen
  import kisc_bus_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr_lo;
      SZ_HALF: begin
        strb     = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        strb     = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master port between instruction fetch (F) and load/store (D).
// Round-robin arbitration in IDLE, APB SETUP/ACCESS sequencing, byte strobes,
// hung-slave timeout, and response routing back to the owning requester.
// Ports: clk/rts_n            - clock, async active-low reset
//        f_* / d_*            - requester handshakes (valid/ready/rsp)
//        rsp_rdata, rsp_err   - response payload, valid with f_rsp/d_rsp
//        p*                   - APB master interface
module apb_bus_arbiter
  import kisc_bus_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rts_n,
  input  logic          f_valid,
  input  logic [AW-1:0] f_addr,
  output logic          f_ready,
  output logic          f_rsp,
  input  logic          d_valid,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rsp,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic [3:0]    pstrb,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_q, state_d;
  owner_e        owner_q, last_grant_q, grant_own_c, rsp_own_c;
  logic [CW-1:0] cnt_q;
  logic          idle_c, grant_d_c, grant_c;
  logic [3:0]    d_strb_c;
  logic          d_misalign_c, req_misalign_c, timeout_c;
  logic          rsp_fire_c, rsp_err_c;
  logic [DW-1:0] rsp_rdata_c;

  apb_strb_gen u_strb_gen (
    .size     (d_size),
    .addr_lo  (d_addr[1:0]),
    .strb     (d_strb_c),
    .misalign (d_misalign_c)
  );

  // Arbitration: D wins a tie only when F was granted last.
  assign idle_c         = rts_n && (state_q == IDLE);
  assign grant_d_c      = d_valid && (!f_valid || (last_grant_q == OWN_F));
  assign f_ready        = idle_c && f_valid && !grant_d_c;
  assign d_ready        = idle_c && grant_d_c;
  assign grant_c        = f_ready || d_ready;
  assign grant_own_c    = d_ready ? OWN_D : OWN_F;
  assign req_misalign_c = d_ready ? d_misalign_c : (f_addr[1:0] != 2'b00);

  // Abort on the ACCESS cycle that would be the TIMEOUT-th without pready.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)) && !pready;

  // State register.
  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and response selection.
  always_comb begin
    state_d     = state_q;
    rsp_fire_c  = 1'b0;
    rsp_own_c   = owner_q;
    rsp_err_c   = 1'b0;
    rsp_rdata_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          if (req_misalign_c) begin
            state_d    = ERR_RSP;
            rsp_fire_c = 1'b1;
            rsp_own_c  = grant_own_c;
            rsp_err_c  = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_fire_c  = 1'b1;
          rsp_err_c   = pslverr;
          rsp_rdata_c = prdata;
        end else if (timeout_c) begin
          state_d    = IDLE;
          rsp_fire_c = 1'b1;
          rsp_err_c  = 1'b1;
        end
      end
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, APB drive, timeout counter and response registers.
  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      owner_q      <= OWN_F;
      last_grant_q <= OWN_F;
      cnt_q        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= 4'b0000;
      pwrite       <= 1'b0;
      f_rsp        <= 1'b0;
      d_rsp        <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      psel    <= (state_d == SETUP) || (state_d == ACCESS);
      penable <= (state_d == ACCESS);
      f_rsp   <= rsp_fire_c && (rsp_own_c == OWN_F);
      d_rsp   <= rsp_fire_c && (rsp_own_c == OWN_D);
      if (rsp_fire_c) begin
        rsp_rdata <= rsp_rdata_c;
        rsp_err   <= rsp_err_c;
      end
      if (grant_c) begin
        owner_q      <= grant_own_c;
        last_grant_q <= grant_own_c;
      end
      // APB fields only change when a real transfer starts, so they hold in IDLE.
      if (grant_c && !req_misalign_c) begin
        paddr  <= d_ready ? d_addr : f_addr;
        pwrite <= d_ready && d_wr;
        pstrb  <= (d_ready && d_wr) ? d_strb_c : 4'b0000;
        if (d_ready) pwdata <= d_wdata;
      end
      if (state_q == SETUP)                         cnt_q <= '0;
      else if ((state_q == ACCESS) && (cnt_q != '1)) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule
